wave_disp_sched: RTL and testbench

Frame-synchronous scheduler for the oscilloscope waveform layer. It owns a ping-pong pair of sample buffers shared between the capture writer and the display reader. Buffers swap only at a frame boundary. Each frame it reads the display buffer column by column and produces a per-pixel waveform hit flag, aligned with delayed sync/de, for the colour mux downstream of the grid generator.

---
 rtl/osc_disp_pkg.sv | 19 +
 rtl/wave_col_pipe.sv | 100 ++++++++++
 rtl/wave_disp_sched.sv | 122 ++++++++++++
 tb/tb_wave_disp_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_disp_pkg.sv
// Shared types and screen geometry for the oscilloscope waveform layer.
// The FSM enum, waveform placement and sample width live here so every block agrees.
package osc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        CAPTURING = 2'd2,
        READY     = 2'd3
    } sched_state_t;

    localparam int WAVE_X0 = 384;
    localparam int WAVE_W  = 1152;
    localparam int WAVE_Y0 = 285;

    localparam int SAMPLE_BITS = 8;
    localparam logic [SAMPLE_BITS-1:0] SAMPLE_MAX = '1;

endpackage

// File: rtl/wave_col_pipe.sv
// Three-stage display pipeline: column address, sample-to-row conversion, and the
// trace hit test between adjacent columns, with sync/de delayed to stay aligned.
module wave_col_pipe #(
    parameter int X_BITS    = 13,
    parameter int Y_BITS    = 13,
    parameter int ADDR_BITS = 11,
    parameter int WAVE_X0   = osc_disp_pkg::WAVE_X0,
    parameter int WAVE_W    = osc_disp_pkg::WAVE_W,
    parameter int WAVE_Y0   = osc_disp_pkg::WAVE_Y0
) (
    input  logic                                pix_clk,
    input  logic                                rstn,
    input  logic [X_BITS-1:0]                   act_x,
    input  logic [Y_BITS-1:0]                   act_y,
    input  logic                                vs_in,
    input  logic                                hs_in,
    input  logic                                de_in,
    output logic                                rd_en,
    output logic [ADDR_BITS-1:0]                rd_addr,
    input  logic [osc_disp_pkg::SAMPLE_BITS-1:0] rd_data,
    output logic                                vs_out,
    output logic                                hs_out,
    output logic                                de_out,
    output logic                                wave_hit
);

    localparam logic [X_BITS-1:0] X_LO = X_BITS'(WAVE_X0);
    localparam logic [X_BITS-1:0] X_HI = X_BITS'(WAVE_X0 + WAVE_W);

    logic              in_win;
    logic              col0;
    logic [2:0]        sync_d1;
    logic [2:0]        sync_d2;
    logic [2:0]        sync_d3;
    logic [Y_BITS-1:0] ay_d1;
    logic [Y_BITS-1:0] ay_d2;
    logic              win_d2;
    logic              first_d1;
    logic              first_d2;
    logic [Y_BITS-1:0] cur_y;
    logic [Y_BITS-1:0] prev_y;
    logic [Y_BITS-1:0] lo_y;
    logic [Y_BITS-1:0] hi_y;

    assign in_win = de_in && (act_x >= X_LO) && (act_x < X_HI);
    assign col0   = (act_x == X_LO);

    // Sample 255 sits on WAVE_Y0; each step down in value moves two rows down.
    assign cur_y = Y_BITS'(WAVE_Y0) + (Y_BITS'(osc_disp_pkg::SAMPLE_MAX - rd_data) << 1);

    always_comb begin
        lo_y = cur_y;
        hi_y = cur_y;
        if (!first_d2) begin
            if (prev_y < cur_y) begin
                lo_y = prev_y;
            end else begin
                hi_y = prev_y;
            end
        end
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            sync_d1  <= '0;
            sync_d2  <= '0;
            sync_d3  <= '0;
            ay_d1    <= '0;
            ay_d2    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            win_d2   <= 1'b0;
            first_d1 <= 1'b0;
            first_d2 <= 1'b0;
            prev_y   <= '0;
            wave_hit <= 1'b0;
        end else begin
            sync_d1  <= {vs_in, hs_in, de_in};
            sync_d2  <= sync_d1;
            sync_d3  <= sync_d2;
            ay_d1    <= act_y;
            ay_d2    <= ay_d1;
            rd_en    <= in_win;
            rd_addr  <= ADDR_BITS'(act_x - X_LO);
            win_d2   <= rd_en;
            first_d1 <= in_win && col0;
            first_d2 <= first_d1;
            wave_hit <= win_d2 && (ay_d2 >= lo_y) && (ay_d2 <= hi_y);
            // Columns outside the window leave the previous trace point untouched.
            if (win_d2) begin
                prev_y <= cur_y;
            end
        end
    end

    assign vs_out = sync_d3[2];
    assign hs_out = sync_d3[1];
    assign de_out = sync_d3[0];

endmodule

// File: rtl/wave_disp_sched.sv
// Frame-synchronous ping-pong scheduler: arms the capture writer, swaps buffers on
// the vsync rising edge once a capture is complete, and drives the display pipeline.
module wave_disp_sched #(
    parameter int X_BITS    = 13,
    parameter int Y_BITS    = 13,
    parameter int ADDR_BITS = 11,
    parameter int WAVE_X0   = osc_disp_pkg::WAVE_X0,
    parameter int WAVE_W    = osc_disp_pkg::WAVE_W,
    parameter int WAVE_Y0   = osc_disp_pkg::WAVE_Y0
) (
    input  logic                                pix_clk,
    input  logic                                rstn,
    input  logic [X_BITS-1:0]                   act_x,
    input  logic [Y_BITS-1:0]                   act_y,
    input  logic                                vs_in,
    input  logic                                hs_in,
    input  logic                                de_in,
    input  logic                                hold,
    input  logic                                cap_done,
    output logic                                cap_start,
    output logic                                cap_buf_sel,
    output logic                                rd_en,
    output logic [ADDR_BITS-1:0]                rd_addr,
    output logic                                rd_buf_sel,
    input  logic [osc_disp_pkg::SAMPLE_BITS-1:0] rd_data,
    output logic                                vs_out,
    output logic                                hs_out,
    output logic                                de_out,
    output logic                                wave_hit,
    output logic [7:0]                          swap_cnt,
    output osc_disp_pkg::sched_state_t          fsm_state
);

    osc_disp_pkg::sched_state_t state;
    osc_disp_pkg::sched_state_t state_nx;
    logic                       cap_start_nx;
    logic                       swap;
    logic                       vs_q;
    logic                       vs_rise;

    // Writer handshake: cap_start is a one-cycle grant of cap_buf_sel; the writer owns
    // that buffer until it returns a one-cycle cap_done. cap_done is only honoured
    // while CAPTURING, and a completed buffer is handed over only at the next vs edge.
    assign vs_rise     = vs_in && !vs_q;
    assign cap_buf_sel = ~rd_buf_sel;
    assign fsm_state   = state;

    always_comb begin
        state_nx     = state;
        cap_start_nx = 1'b0;
        swap         = 1'b0;
        case (state)
            osc_disp_pkg::IDLE: begin
                state_nx = osc_disp_pkg::ARM;
            end
            osc_disp_pkg::ARM: begin
                if (!hold) begin
                    cap_start_nx = 1'b1;
                    state_nx     = osc_disp_pkg::CAPTURING;
                end
            end
            osc_disp_pkg::CAPTURING: begin
                // A vs edge in the same cycle as cap_done is deliberately not a swap.
                if (cap_done) begin
                    state_nx = osc_disp_pkg::READY;
                end
            end
            osc_disp_pkg::READY: begin
                if (vs_rise) begin
                    swap     = 1'b1;
                    state_nx = osc_disp_pkg::ARM;
                end
            end
            default: begin
                state_nx = osc_disp_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= osc_disp_pkg::IDLE;
            cap_start  <= 1'b0;
            rd_buf_sel <= 1'b0;
            swap_cnt   <= '0;
            vs_q       <= 1'b0;
        end else begin
            state     <= state_nx;
            cap_start <= cap_start_nx;
            vs_q      <= vs_in;
            if (swap) begin
                rd_buf_sel <= ~rd_buf_sel;
                swap_cnt   <= swap_cnt + 8'd1;
            end
        end
    end

    wave_col_pipe #(
        .X_BITS    (X_BITS),
        .Y_BITS    (Y_BITS),
        .ADDR_BITS (ADDR_BITS),
        .WAVE_X0   (WAVE_X0),
        .WAVE_W    (WAVE_W),
        .WAVE_Y0   (WAVE_Y0)
    ) u_col_pipe (
        .pix_clk  (pix_clk),
        .rstn     (rstn),
        .act_x    (act_x),
        .act_y    (act_y),
        .vs_in    (vs_in),
        .hs_in    (hs_in),
        .de_in    (de_in),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .vs_out   (vs_out),
        .hs_out   (hs_out),
        .de_out   (de_out),
        .wave_hit (wave_hit)
    );

endmodule

// File: tb/tb_wave_disp_sched.sv
// Directed scheduler sequence plus randomized sample buffers, checked against a
// column-by-column trace model and a 3-deep expected queue of {vs,hs,de,hit}.
module tb_wave_disp_sched;

    logic        pix_clk = 1'b0;
    logic        rstn = 1'b0;
    logic [12:0] act_x = '0;
    logic [12:0] act_y = '0;
    logic        vs_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        de_in = 1'b0;
    logic        hold = 1'b0;
    logic        cap_done = 1'b0;
    logic        cap_start;
    logic        cap_buf_sel;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic        rd_buf_sel;
    logic [7:0]  rd_data = '0;
    logic        vs_out;
    logic        hs_out;
    logic        de_out;
    logic        wave_hit;
    logic [7:0]  swap_cnt;
    osc_disp_pkg::sched_state_t fsm_state;

    wave_disp_sched dut (
        .pix_clk     (pix_clk),
        .rstn        (rstn),
        .act_x       (act_x),
        .act_y       (act_y),
        .vs_in       (vs_in),
        .hs_in       (hs_in),
        .de_in       (de_in),
        .hold        (hold),
        .cap_done    (cap_done),
        .cap_start   (cap_start),
        .cap_buf_sel (cap_buf_sel),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_buf_sel  (rd_buf_sel),
        .rd_data     (rd_data),
        .vs_out      (vs_out),
        .hs_out      (hs_out),
        .de_out      (de_out),
        .wave_hit    (wave_hit),
        .swap_cnt    (swap_cnt),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 pix_clk = ~pix_clk;

    // sample buffer memory: one-cycle read latency
    logic [7:0] mem [2][1152];
    always @(posedge pix_clk) begin
        if (rd_en && rd_addr < 11'd1152) rd_data <= mem[rd_buf_sel][rd_addr];
    end

    // scoreboard state
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    int         model_prev = 0;
    int         exp_sel = 0;
    int         hit_obs = 0;
    logic       hold_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One pixel clock: check the output due from 3 cycles ago, then apply new inputs.
    task automatic tick(input int x, input int y, input logic vs, input logic hs,
                        input logic de, input logic done);
        logic [3:0] e;
        logic       hit;
        int         cy;
        int         lo;
        int         hi;
        @(negedge pix_clk);
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            chk("pipe_vs_hs_de_hit", {28'd0, vs_out, hs_out, de_out, wave_hit}, {28'd0, e});
            if (wave_hit) hit_obs++;
        end
        hit = 1'b0;
        if (de && x >= 384 && x < 1536) begin
            cy = 285 + 2 * (255 - int'(mem[exp_sel][x - 384]));
            if (x == 384) begin
                lo = cy;
                hi = cy;
            end else begin
                lo = (model_prev < cy) ? model_prev : cy;
                hi = (model_prev < cy) ? cy : model_prev;
            end
            hit = (y >= lo) && (y <= hi);
            model_prev = cy;
        end
        exp_q.push_back({vs, hs, de, hit});
        act_x    = 13'(x);
        act_y    = 13'(y);
        vs_in    = vs;
        hs_in    = hs;
        de_in    = de;
        cap_done = done;
        hold     = hold_v;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_tick(input int n);
        repeat (n) tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_line(input int y, input bit rnd_de);
        logic de;
        for (int x = 380; x < 1540; x++) begin
            de = rnd_de ? ($urandom_range(0, 15) != 0) : 1'b1;
            tick(x, y, 1'b0, 1'b0, de, 1'b0);
        end
        repeat (4) tick(0, y, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fill(input int b, input bit constant);
        for (int i = 0; i < 1152; i++) begin
            mem[b][i] = constant ? 8'd128 : 8'($urandom_range(0, 255));
        end
    endtask

    // Asynchronous reset between edges; reset values must appear without a clock.
    task automatic do_reset();
        @(negedge pix_clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_vs_out", vs_out, 0);
        chk("rst_hs_out", hs_out, 0);
        chk("rst_de_out", de_out, 0);
        chk("rst_wave_hit", wave_hit, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_buf_sel", rd_buf_sel, 0);
        chk("rst_cap_buf_sel", cap_buf_sel, 1);
        chk("rst_cap_start", cap_start, 0);
        chk("rst_swap_cnt", swap_cnt, 0);
        chk("rst_state", fsm_state, osc_disp_pkg::IDLE);
        act_x = '0; act_y = '0; vs_in = 0; hs_in = 0; de_in = 0; cap_done = 0;
        hold_v = 1'b0;
        hold = 1'b0;
        exp_q.delete();
        repeat (3) exp_q.push_back(4'd0);
        model_prev = 0;
        exp_sel = 0;
        @(negedge pix_clk);
        @(negedge pix_clk);
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        int n;
        fill(0, 1'b0);
        fill(1, 1'b0);

        // reset release and first arm
        do_reset();
        idle(1);
        chk("arm_cs_early", cap_start, 0);
        idle(1);
        chk("arm_cs", cap_start, 1);
        chk("arm_cap_buf_sel", cap_buf_sel, 1);
        chk("arm_rd_buf_sel", rd_buf_sel, 0);
        idle(1);
        chk("arm_cs_once", cap_start, 0);

        // writer fills buffer 1 with mid-scale; swap at the next vs edge
        fill(1, 1'b1);
        idle(2);
        tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("done_no_swap", rd_buf_sel, 0);
        vs_tick(2);
        chk("swap1_rd_sel", rd_buf_sel, 1);
        chk("swap1_cap_sel", cap_buf_sel, 0);
        chk("swap1_cnt", swap_cnt, 1);
        chk("swap1_cs_wait", cap_start, 0);
        vs_tick(1);
        chk("swap1_rearm_cs", cap_start, 1);
        exp_sel = 1;
        vs_tick(3);
        idle(3);
        vs_tick(2);
        chk("vs_no_done_sel", rd_buf_sel, 1);
        chk("vs_no_done_cnt", swap_cnt, 1);
        idle(3);

        // constant 128: only row 539 across the whole window
        hit_obs = 0;
        drive_line(538, 1'b0);
        drive_line(539, 1'b0);
        drive_line(540, 1'b0);
        idle(3);
        chk("const_hit_count", hit_obs, 1152);

        // buffer 0: full-scale then zero on the first two columns
        fill(0, 1'b0);
        mem[0][0] = 8'd255;
        mem[0][1] = 8'd0;
        tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        vs_tick(2);
        chk("swap2_rd_sel", rd_buf_sel, 0);
        chk("swap2_cnt", swap_cnt, 2);
        exp_sel = 0;
        vs_tick(2);
        idle(3);
        hit_obs = 0;
        drive_line(285, 1'b0);
        drive_line(795, 1'b0);
        drive_line(284, 1'b0);
        drive_line(796, 1'b0);
        drive_line(500, 1'b0);
        drive_line(int'($urandom_range(280, 800)), 1'b1);
        drive_line(int'($urandom_range(280, 800)), 1'b1);
        idle(3);

        // hold during capture: swap still happens, re-arm is blocked
        hold_v = 1'b1;
        fill(1, 1'b0);
        idle(2);
        tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        vs_tick(2);
        chk("hold_swap_sel", rd_buf_sel, 1);
        chk("hold_swap_cnt", swap_cnt, 3);
        exp_sel = 1;
        n = 0;
        repeat (8) begin
            idle(1);
            if (cap_start) n++;
        end
        chk("hold_no_cs", n, 0);
        drive_line(int'($urandom_range(280, 800)), 1'b1);
        drive_line(int'($urandom_range(280, 800)), 1'b1);
        n = 0;
        idle(3);
        if (cap_start) n++;
        chk("hold_line_no_cs", n, 0);
        hold_v = 1'b0;
        idle(1);
        chk("unhold_cs_wait", cap_start, 0);
        idle(1);
        chk("unhold_cs", cap_start, 1);

        // cap_done coincident with vs edge: swap waits a frame
        fill(0, 1'b0);
        idle(2);
        tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        vs_tick(1);
        chk("coinc_no_swap_sel", rd_buf_sel, 1);
        chk("coinc_no_swap_cnt", swap_cnt, 3);
        vs_tick(3);
        chk("coinc_still_sel", rd_buf_sel, 1);
        idle(2);
        vs_tick(2);
        chk("deferred_swap_sel", rd_buf_sel, 0);
        chk("deferred_swap_cnt", swap_cnt, 4);
        exp_sel = 0;
        vs_tick(1);
        chk("deferred_rearm_cs", cap_start, 1);
        idle(3);
        drive_line(int'($urandom_range(280, 800)), 1'b1);

        // reset mid-capture with a busy pipeline
        repeat (4) tick(400, 600, 1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        idle(1);
        chk("rst_rearm_cs_early", cap_start, 0);
        idle(1);
        chk("rst_rearm_cs", cap_start, 1);
        chk("rst_rearm_cap_sel", cap_buf_sel, 1);
        chk("rst_rearm_cnt", swap_cnt, 0);
        drive_line(int'($urandom_range(280, 800)), 1'b1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
